// File: rtl/yarp_lsu_if.sv
// Core-side and memory-side signal bundles for the yarp load/store unit.
// The LSU serves the core (slave) and masters the data-memory port.
interface yarp_lsu_core_if #(parameter int XLEN = 32, parameter int ADDR_W = 32);
  logic              lsu_req_i;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [1:0]        lsu_size_i;
  logic              lsu_wr_i;
  logic [XLEN-1:0]   lsu_wr_data_i;
  logic              lsu_zero_extnd_i;
  logic              lsu_busy_o;
  logic              lsu_done_o;
  logic [XLEN-1:0]   lsu_rd_data_o;
  logic              lsu_misalign_o;
  logic              lsu_err_o;

  modport master (output lsu_req_i, lsu_addr_i, lsu_size_i, lsu_wr_i, lsu_wr_data_i, lsu_zero_extnd_i,
                  input  lsu_busy_o, lsu_done_o, lsu_rd_data_o, lsu_misalign_o, lsu_err_o);
  modport slave  (input  lsu_req_i, lsu_addr_i, lsu_size_i, lsu_wr_i, lsu_wr_data_i, lsu_zero_extnd_i,
                  output lsu_busy_o, lsu_done_o, lsu_rd_data_o, lsu_misalign_o, lsu_err_o);
endinterface

interface yarp_lsu_mem_if #(parameter int XLEN = 32, parameter int ADDR_W = 32);
  logic              mem_req_o;
  logic              mem_gnt_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_wr_o;
  logic [XLEN/8-1:0] mem_be_o;
  logic [XLEN-1:0]   mem_wr_data_o;
  logic              mem_rvalid_i;
  logic [XLEN-1:0]   mem_rd_data_i;
  logic              mem_err_i;

  modport master (output mem_req_o, mem_addr_o, mem_wr_o, mem_be_o, mem_wr_data_o,
                  input  mem_gnt_i, mem_rvalid_i, mem_rd_data_i, mem_err_i);
  modport slave  (input  mem_req_o, mem_addr_o, mem_wr_o, mem_be_o, mem_wr_data_o,
                  output mem_gnt_i, mem_rvalid_i, mem_rd_data_i, mem_err_i);
endinterface

// File: rtl/yarp_lsu.sv
// Load/store unit: one access at a time, alignment check, lane steering,
// req/gnt + rvalid memory handshake with response timeout, load extension.
module yarp_lsu #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic           clk,
  input  logic           reset_n,
  yarp_lsu_core_if.slave core,
  yarp_lsu_mem_if.master mem
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              wr_q, zx_q;
  logic [OFF_W-1:0]  off_q, off_in;
  logic [NB-1:0]     be_q;
  logic [XLEN-1:0]   wdata_q, rd_data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q, done_q, misalign_q, err_q, mem_req_q;
  logic              misalign_in, accept, timeout;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic [3:0] o;
    o = 4'(off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return o[0];
      2'b10:   return |o[1:0];
      default: return (XLEN == 32) || (|o[2:0]);
    endcase
  endfunction

  // Replicate the right-justified operand across the bus, then move it to its lane.
  function automatic logic [XLEN-1:0] steer_data(input logic [XLEN-1:0] d, input logic [1:0] size,
                                                 input logic [OFF_W-1:0] off);
    logic [XLEN-1:0] rep;
    int span;
    span = ((1 << size) > NB) ? NB : (1 << size);
    for (int i = 0; i < NB; i++) rep[i*8 +: 8] = d[(i % span)*8 +: 8];
    return rep << {off, 3'b000};
  endfunction

  function automatic logic [NB-1:0] steer_be(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic [7:0] base;
    case (size)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      2'b10:   base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return NB'(base) << off;
  endfunction

  // Sizes as wide as the bus pass through untouched.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw, input logic [1:0] size,
                                                  input logic [OFF_W-1:0] off, input logic zx);
    logic [XLEN-1:0] sh, res;
    int bits;
    sh   = raw >> {off, 3'b000};
    bits = 8 << size;
    res  = sh;
    for (int b = 0; b < XLEN; b++) if (b >= bits) res[b] = ~zx & sh[bits-1];
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    off_in      = core.lsu_addr_i[OFF_W-1:0];
    misalign_in = is_misaligned(core.lsu_size_i, off_in);
    timeout     = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    case (state_q)
      IDLE: if (core.lsu_req_i) begin
        accept = 1'b1;
        if (!misalign_in) state_d = REQ;
      end
      REQ:  if (mem.mem_gnt_i) state_d = WAIT;
      WAIT: if (mem.mem_rvalid_i || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      size_q     <= '0;
      wr_q       <= 1'b0;
      zx_q       <= 1'b0;
      off_q      <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
      mem_req_q  <= 1'b0;
    end else begin
      busy_q     <= (state_d != IDLE);
      mem_req_q  <= (state_d == REQ);
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
      if (accept) begin
        addr_q  <= {core.lsu_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        size_q  <= core.lsu_size_i;
        wr_q    <= core.lsu_wr_i;
        zx_q    <= core.lsu_zero_extnd_i;
        off_q   <= off_in;
        be_q    <= steer_be(core.lsu_size_i, off_in);
        wdata_q <= steer_data(core.lsu_wr_data_i, core.lsu_size_i, off_in);
        if (misalign_in) begin
          done_q     <= 1'b1;
          misalign_q <= 1'b1;
          rd_data_q  <= '0;
        end
      end
      // A response arriving on the timeout cycle still completes normally.
      if (state_q == WAIT) begin
        if (mem.mem_rvalid_i) begin
          done_q    <= 1'b1;
          err_q     <= mem.mem_err_i;
          rd_data_q <= wr_q ? '0 : load_extend(mem.mem_rd_data_i, size_q, off_q, zx_q);
        end else if (timeout) begin
          done_q    <= 1'b1;
          err_q     <= 1'b1;
          rd_data_q <= '0;
        end
      end
    end
  end

  assign core.lsu_busy_o     = busy_q;
  assign core.lsu_done_o     = done_q;
  assign core.lsu_rd_data_o  = rd_data_q;
  assign core.lsu_misalign_o = misalign_q;
  assign core.lsu_err_o      = err_q;
  assign mem.mem_req_o       = mem_req_q;
  assign mem.mem_addr_o      = addr_q;
  assign mem.mem_wr_o        = wr_q;
  assign mem.mem_be_o        = be_q;
  assign mem.mem_wr_data_o   = wdata_q;
endmodule

// File: doc/yarp_lsu.md
Name: yarp_lsu

Overview:
Parametrised load/store unit between the execute stage and the data memory port. It accepts one load/store at a time from the core and checks alignment. It steers byte lanes and generates byte strobes, runs a req/gnt + rvalid handshake with memory that tolerates wait states, and returns sign/zero-extended load data. A response timeout and a memory error path report failures to the core.

Parameters:
XLEN, 32, data width; legal values 32 or 64. NB = XLEN/8 byte lanes; OFF_W = log2(NB).
ADDR_W, 32, address width.
TIMEOUT_CYCLES, 256, maximum cycles in WAIT before aborting with error; 0 disables the timeout.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
lsu_req_i  in  1  core request; sampled only when lsu_busy_o=0
lsu_addr_i  in  ADDR_W  byte address
lsu_size_i  in  2  00 BYTE, 01 HALF_WORD, 10 WORD, 11 DOUBLE (legal only when XLEN=64)
lsu_wr_i  in  1  1 = store, 0 = load
lsu_wr_data_i  in  XLEN  store data, right-justified
lsu_zero_extnd_i  in  1  1 = zero-extend load, 0 = sign-extend
lsu_busy_o  out  1  high while the FSM is not in IDLE
lsu_done_o  out  1  one-cycle completion pulse
lsu_rd_data_o  out  XLEN  extended load data; valid while lsu_done_o=1 and held until the next completion
lsu_misalign_o  out  1  qualifies lsu_done_o: access was misaligned or illegal
lsu_err_o  out  1  qualifies lsu_done_o: memory error or timeout
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory accepts request
mem_addr_o  out  ADDR_W  address with low OFF_W bits cleared
mem_wr_o  out  1  write
mem_be_o  out  NB  byte strobes
mem_wr_data_o  out  XLEN  lane-steered store data
mem_rvalid_i  in  1  response valid (reads and writes)
mem_rd_data_i  in  XLEN  full-width read data
mem_err_i  in  1  error; qualified by mem_rvalid_i

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. All outputs and internal registers are 0, including mem_req_o and lsu_done_o. A transaction in flight is dropped with no done pulse.
- All outputs are driven from registers.
- FSM states: IDLE, REQ, WAIT.
- IDLE, lsu_req_i=1: latch addr, size, wr, zero_extnd and data; off = addr[OFF_W-1:0].
  - Misaligned when: HALF_WORD and off[0]!=0; WORD and off[1:0]!=0; DOUBLE and off[2:0]!=0; or size=11 with XLEN=32.
  - Misaligned: stay in IDLE, no memory access. Next cycle: lsu_done_o=1, lsu_misalign_o=1, lsu_rd_data_o=0.
  - Otherwise go to REQ.
- REQ: mem_req_o=1 with stable addr/wr/be/wr_data until mem_gnt_i=1, then go to WAIT. mem_req_o drops the cycle after the grant. mem_rvalid_i in REQ is ignored.
- WAIT: timeout counter increments each cycle.
  - On mem_rvalid_i: latch data and go to IDLE. Next cycle: lsu_done_o=1; lsu_err_o=mem_err_i; load data steered and extended; store leaves lsu_rd_data_o=0.
  - If the counter reaches TIMEOUT_CYCLES (when nonzero): go to IDLE with done=1, err=1, rd_data=0.
  - If rvalid and timeout occur in the same cycle, rvalid wins.
- Pipelining: a new request is accepted in the same cycle lsu_done_o is high, because the FSM is already in IDLE.
- Minimum latency, aligned access with immediate grant and rvalid one cycle later: accept at cycle 0, mem_req_o at cycle 1, WAIT at cycle 2, lsu_done_o at cycle 3.
- Misaligned access latency: done at cycle 1.
- Store steering:
  - mem_wr_data_o = lsu_wr_data_i replicated per size, shifted left by off*8.
  - mem_be_o = {1, 2'b11, 4'hF, 8'hFF}[size] << off.
  - mem_wr_data_o and mem_be_o are still valid for loads; memory ignores them.
- Load extraction: shift mem_rd_data_i right by off*8, then extend from bit 7/15/31 according to size (the same rule as the existing data-memory path). DOUBLE passes through unchanged. WORD on XLEN=32 passes through unchanged.
- lsu_misalign_o and lsu_err_o are 0 whenever lsu_done_o=0.

Test Plan:
1. XLEN=32. Store BYTE 0xA5 to addr 0x1003 → mem_addr_o=0x1000, mem_be_o=4'b1000, mem_wr_data_o[31:24]=0xA5. lsu_done_o at cycle 3 with no errors.
2. Load HALF_WORD, sign-extend, addr 0x2002, mem returns 0x80F1_1234 → lsu_rd_data_o=0xFFFF_80F1. Same load with lsu_zero_extnd_i=1 → 0x0000_80F1.
3. Load WORD at 0x3001 → no mem_req_o, lsu_done_o and lsu_misalign_o at cycle 1. Size=11 at XLEN=32 → same misalign response.
4. mem_gnt_i held low for 5 cycles, then rvalid 3 cycles after the grant → mem_req_o stable for 6 cycles, lsu_busy_o high throughout, done exactly once. Back-to-back request accepted in the done cycle completes correctly.
5. TIMEOUT_CYCLES=4, rvalid never arrives → done with lsu_err_o=1 after 4 WAIT cycles. mem_err_i=1 with rvalid → done with err=1.
6. reset_n pulled low in WAIT → mem_req_o and lsu_busy_o are 0 immediately, no done pulse. After reset release, a fresh load completes normally. XLEN=64: DOUBLE load at 0x8 with offset 0 passes data unchanged.
